// File: rtl/fir_seq_ctrl.sv
// Sequential FIR filter: one shared 16x8 MAC walks NTAPS taps of a circular
// sample buffer per accepted sample, with a fixed and a programmable coefficient bank.
module fir_seq_ctrl #(
  parameter int NTAPS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        coef_sel,
  input  logic        coef_we,
  input  logic [4:0]  coef_addr,
  input  logic [15:0] coef_data,
  output logic        coef_err_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        busy_o
);

  // state  | meaning
  // S_IDLE | waiting for a sample; only state where samples and coefficient writes land
  // S_MAC  | one tap per cycle, k = 0 .. NTAPS-1
  // S_OUT  | scale, saturate and register the result; advance write pointer
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  state_t r_state;
  state_t w_next;

  logic signed [7:0]  r_buf   [NTAPS];
  logic signed [15:0] r_bank1 [NTAPS];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_k;
  logic               r_sel;
  logic signed [24:0] r_acc;
  logic [7:0]         r_data_o;
  logic               r_valid_o;
  logic               r_coef_err;

  logic               w_accept;
  logic               w_addr_ok;
  logic               w_wr_ok;
  logic               w_wr_err;
  logic [AW-1:0]      w_rd_idx;
  logic signed [15:0] w_coef;
  logic signed [7:0]  w_samp;
  logic signed [23:0] w_prod;
  logic signed [24:0] w_shift;
  logic [7:0]         w_sat;

  function automatic logic signed [15:0] fixed_coef(input logic [AW-1:0] idx);
    case (int'(idx))
      1, 11:   return 16'hF5B1;
      2, 10:   return 16'hF2FD;
      4, 8:    return 16'h1A5B;
      5, 7:    return 16'h34DF;
      6:       return 16'h4000;
      default: return 16'h0000;
    endcase
  endfunction

  assign w_accept  = valid_i && (r_state == S_IDLE);
  assign w_addr_ok = int'(coef_addr) < NTAPS;
  assign w_wr_ok   = coef_we && (r_state == S_IDLE) && w_addr_ok;
  assign w_wr_err  = coef_we && !w_wr_ok;

  // Newest sample sits at wptr, so tap k reads k entries behind it.
  always_comb begin
    if (r_wptr >= r_k) w_rd_idx = r_wptr - r_k;
    else               w_rd_idx = AW'(int'(r_wptr) + NTAPS - int'(r_k));
  end

  assign w_coef  = r_sel ? r_bank1[r_k] : fixed_coef(r_k);
  assign w_samp  = r_buf[w_rd_idx];
  assign w_prod  = w_coef * w_samp;
  assign w_shift = r_acc >>> 14;

  always_comb begin
    if (w_shift > 25'sd127)       w_sat = 8'h7F;
    else if (w_shift < -25'sd128) w_sat = 8'h80;
    else                          w_sat = w_shift[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (valid_i) w_next = S_MAC;
      S_MAC:   if (r_k == K_LAST) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_buf[i]   <= '0;
        r_bank1[i] <= '0;
      end
      r_wptr     <= '0;
      r_k        <= '0;
      r_sel      <= 1'b0;
      r_acc      <= '0;
      r_data_o   <= '0;
      r_valid_o  <= 1'b0;
      r_coef_err <= 1'b0;
    end else begin
      r_valid_o  <= 1'b0;
      r_coef_err <= w_wr_err;
      if (w_wr_ok) r_bank1[AW'(coef_addr)] <= coef_data;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_buf[r_wptr] <= data_i;
            r_sel         <= coef_sel;
            r_acc         <= '0;
            r_k           <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + {w_prod[23], w_prod};
          r_k   <= r_k + AW'(1);
        end
        S_OUT: begin
          r_data_o  <= w_sat;
          r_valid_o <= 1'b1;
          r_wptr    <= (r_wptr == K_LAST) ? '0 : r_wptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign ready_o    = (r_state == S_IDLE);
  assign busy_o     = (r_state != S_IDLE);
  assign data_o     = r_data_o;
  assign valid_o    = r_valid_o;
  assign coef_err_o = r_coef_err;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed plus randomized bench for fir_seq_ctrl against a convolution model
// built from the sample history and the two coefficient banks.
module tb_fir_seq_ctrl;
  localparam int NTAPS = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic        coef_sel;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_err_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        busy_o;

  fir_seq_ctrl #(.NTAPS(NTAPS)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .coef_sel(coef_sel), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err_o(coef_err_o), .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic signed [15:0] h0 [NTAPS] = '{16'h0000, 16'hF5B1, 16'hF2FD, 16'h0000, 16'h1A5B,
                                     16'h34DF, 16'h4000, 16'h34DF, 16'h1A5B, 16'h0000,
                                     16'hF2FD, 16'hF5B1, 16'h0000, 16'h0000, 16'h0000,
                                     16'h0000, 16'h0000};
  logic [7:0] imp_exp [NTAPS] = '{8'h00, 8'hEB, 8'hE6, 8'h00, 8'h34, 8'h68, 8'h7F, 8'h68,
                                  8'h34, 8'h00, 8'hE6, 8'hEB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic signed [15:0] h1 [NTAPS];
  int hist[$];
  logic [7:0] obs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_out(input bit sel);
    int sum = 0;
    int y;
    for (int k = 0; k < NTAPS; k++)
      if (k < hist.size()) sum += (sel ? int'(h1[k]) : int'(h0[k])) * hist[k];
    y = sum / 16384;
    if (sum < 0 && (sum % 16384) != 0) y = y - 1;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    hist.delete();
    for (int i = 0; i < NTAPS; i++) h1[i] = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1; valid_i = 1'b0; coef_we = 1'b0;
    tick; tick;
    rst = 1'b0;
    model_reset();
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_err", coef_err_o, 0);
  endtask

  task automatic send(input logic [7:0] d, input bit sel, input bit acc_wr, input bit mid_wr,
                      input logic [4:0] wa, input logic [15:0] wd, output logic [7:0] got);
    logic [7:0] exp;
    chk("ready_before", ready_o, 1);
    valid_i = 1'b1; data_i = d; coef_sel = sel;
    coef_we = acc_wr; coef_addr = wa; coef_data = wd;
    tick;
    valid_i = 1'b0; coef_we = 1'b0;
    if (acc_wr) h1[wa] = wd;
    hist.push_front(int'($signed(d)));
    if (hist.size() > NTAPS) void'(hist.pop_back());
    exp = model_out(sel);
    chk("err_accept", coef_err_o, 0);
    chk("valid_one_cycle", valid_o, 0);
    for (int i = 1; i <= 17; i++) begin
      valid_i = 1'($urandom); data_i = 8'($urandom); coef_sel = 1'($urandom);
      coef_we = mid_wr && (i == 5); coef_addr = wa; coef_data = wd;
      tick;
      chk("busy", busy_o, 1);
      chk("ready_low", ready_o, 0);
      chk("no_early_valid", valid_o, 0);
      chk("err_mid", coef_err_o, 32'(mid_wr && (i == 5)));
    end
    valid_i = 1'($urandom); coef_sel = 1'($urandom); coef_we = 1'b0;
    tick;
    valid_i = 1'b0;
    chk("valid_at_18", valid_o, 1);
    chk("data_o", data_o, exp);
    chk("ready_after", ready_o, 1);
    chk("busy_after", busy_o, 0);
    got = data_o;
  endtask

  task automatic send_s(input logic [7:0] d, input bit sel);
    send(d, sel, 1'b0, 1'b0, 5'd0, 16'h0000, obs);
  endtask

  task automatic coef_write(input logic [4:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick;
    coef_we = 1'b0;
    chk("coef_err", coef_err_o, 32'(a > 5'd16));
    if (a <= 5'd16) h1[a] = d;
    tick;
    chk("coef_err_pulse", coef_err_o, 0);
  endtask

  task automatic reset_mid;
    chk("ready_mid", ready_o, 1);
    valid_i = 1'b1; data_i = 8'h55; coef_sel = 1'b0;
    tick;
    valid_i = 1'b0;
    repeat (8) tick;
    chk("busy_k8", busy_o, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset();
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_data", data_o, 0);
    for (int i = 0; i < 25; i++) begin
      tick;
      chk("mid_rst_no_valid", valid_o, 0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; data_i = '0; valid_i = 1'b0; coef_sel = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    do_reset();

    for (int n = 0; n < NTAPS; n++) begin
      send_s((n == 0) ? 8'h7F : 8'h00, 1'b0);
      chk("impulse_table", obs, imp_exp[n]);
    end

    for (int n = 0; n < NTAPS; n++) send_s(8'h7F, 1'b0);
    chk("sat_pos", obs, 8'h7F);
    for (int n = 0; n < NTAPS; n++) send_s(8'h80, 1'b0);
    chk("sat_neg", obs, 8'h80);

    coef_write(5'd0, 16'h4000);
    send_s(8'h40, 1'b1);
    chk("prog_unity", obs, 8'h40);
    send(8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 16'h2000, obs);
    send_s(8'h40, 1'b1);
    chk("prog_mid_dropped", obs, 8'h40);

    coef_write(5'd17, 16'h7FFF);
    coef_write(5'd31, 16'h1234);
    for (int n = 0; n < 3; n++) send_s(8'h40, 1'b1);
    chk("bad_addr_nochange", obs, 8'h40);

    send(8'h40, 1'b1, 1'b1, 1'b0, 5'd0, 16'h2000, obs);
    chk("same_edge_write", obs, 8'h20);

    coef_write(5'd3, 16'h4000);
    reset_mid();
    for (int n = 0; n < NTAPS; n++) begin
      send_s((n == 0) ? 8'h7F : 8'h00, 1'b0);
      chk("impulse_after_rst", obs, imp_exp[n]);
    end
    for (int n = 0; n < 4; n++) send_s(8'h7F, 1'b1);
    chk("bank1_cleared", obs, 8'h00);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        coef_write(5'($urandom_range(0, 31)), 16'($urandom_range(0, 8191) - 4096));
      if ($urandom_range(0, 2) == 0)
        send(8'($urandom), 1'($urandom), 1'b1, 1'b0, 5'($urandom_range(0, 16)),
             16'($urandom_range(0, 8191) - 4096), obs);
      else
        send_s(8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
